datapath_banked: RTL

Parametrised successor of the 4-bit accumulator datapath: one accumulator, one carry flag, and a register file generalised to `WIDTH`-bit words, `NREGS` registers per bank and `NBANKS` banks. It decodes its own 4-bit operation code and has an internal ALU. New over the previous generation: bank switching, a two-beat register-pair load with a busy handshake, decimal adjust, increment-and-test, and a synchronised `test` pin feeding branch evaluation. It sits between the instruction decoder and the external data bus.

---
 rtl/datapath_banked.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/datapath_banked.sv
// Banked accumulator datapath: one accumulator, one carry flag and NBANKS x NREGS registers.
// Includes an internal op decoder and ALU, a two-beat pair load (FIM) and branch evaluation.
module datapath_banked #(
  parameter int WIDTH  = 4,
  parameter int NREGS  = 16,
  parameter int NBANKS = 2
) (
  input  logic                                        clock,
  input  logic                                        reset_n,
  input  logic                                        halt,
  input  logic                                        op_valid,
  input  logic [3:0]                                  op,
  input  logic [$clog2(NREGS)-1:0]                    reg_sel,
  input  logic [WIDTH-1:0]                            imm,
  input  logic [WIDTH-1:0]                            data,
  input  logic [3:0]                                  cond,
  input  logic                                        test,
  output logic [WIDTH-1:0]                            acc,
  output logic                                        carry,
  output logic [WIDTH-1:0]                            regval,
  output logic [(NBANKS > 1 ? $clog2(NBANKS) : 1)-1:0] bank,
  output logic                                        busy,
  output logic                                        take_branch,
  output logic                                        reg_is_zero
);
  localparam int RW = $clog2(NREGS);
  localparam int BW = (NBANKS > 1) ? $clog2(NBANKS) : 1;

  localparam logic [3:0] OP_LD  = 4'd1,  OP_XCH = 4'd2,  OP_ADD = 4'd3,  OP_SUB = 4'd4;
  localparam logic [3:0] OP_INC = 4'd5,  OP_LDM = 4'd6,  OP_RDD = 4'd7,  OP_WRR = 4'd8;
  localparam logic [3:0] OP_CLB = 4'd9,  OP_CLC = 4'd10, OP_STC = 4'd11, OP_DAA = 4'd12;
  localparam logic [3:0] OP_FIM = 4'd13, OP_BNK = 4'd14, OP_ISZ = 4'd15;

  typedef enum logic {S_IDLE = 1'b0, S_BEAT2 = 1'b1} state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_regs [NBANKS][NREGS];
  logic [WIDTH-1:0] r_acc, w_acc_next;
  logic             r_carry, w_carry_next;
  logic [BW-1:0]    r_bank, w_bank_next;
  logic [BW-1:0]    r_fim_bank, w_fim_bank_next;
  logic [RW-1:0]    r_fim_addr, w_fim_addr_next;
  logic             r_test_s1, r_test_s2;

  logic             w_we;
  logic [BW-1:0]    w_wbank;
  logic [RW-1:0]    w_waddr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_rd;
  logic [WIDTH:0]   w_add, w_sub, w_daa;
  logic [WIDTH-1:0] w_inc;

  assign w_rd  = r_regs[r_bank][reg_sel];
  assign w_add = {1'b0, r_acc} + {1'b0, w_rd} + {{WIDTH{1'b0}}, r_carry};
  // carry=1 means "no borrow", so it enters the subtract as the +1 of the two's complement
  assign w_sub = {1'b0, r_acc} + {1'b0, ~w_rd} + {{WIDTH{1'b0}}, r_carry};
  assign w_daa = {1'b0, r_acc} + (WIDTH + 1)'(6);
  assign w_inc = w_rd + WIDTH'(1);

  always_comb begin
    w_state_next    = r_state;
    w_acc_next      = r_acc;
    w_carry_next    = r_carry;
    w_bank_next     = r_bank;
    w_fim_bank_next = r_fim_bank;
    w_fim_addr_next = r_fim_addr;
    w_we            = 1'b0;
    w_wbank         = r_bank;
    w_waddr         = reg_sel;
    w_wdata         = data;
    case (r_state)
      S_IDLE: begin
        if (op_valid) begin
          case (op)
            OP_LD:  w_acc_next = w_rd;
            OP_XCH: begin w_acc_next = w_rd; w_we = 1'b1; w_wdata = r_acc; end
            OP_ADD: {w_carry_next, w_acc_next} = w_add;
            OP_SUB: {w_carry_next, w_acc_next} = w_sub;
            OP_INC, OP_ISZ: begin w_we = 1'b1; w_wdata = w_inc; end
            OP_LDM: w_acc_next = imm;
            OP_RDD: w_acc_next = data;
            OP_WRR: w_we = 1'b1;
            OP_CLB: begin w_acc_next = '0; w_carry_next = 1'b0; end
            OP_CLC: w_carry_next = 1'b0;
            OP_STC: w_carry_next = 1'b1;
            OP_DAA: begin
              if (WIDTH == 4 && (r_acc > WIDTH'(9) || r_carry)) begin
                w_acc_next   = w_daa[WIDTH-1:0];
                w_carry_next = r_carry | w_daa[WIDTH];
              end
            end
            OP_FIM: begin
              w_we            = 1'b1;
              w_waddr         = reg_sel & ~RW'(1);
              w_fim_addr_next = reg_sel | RW'(1);
              w_fim_bank_next = r_bank;
              w_state_next    = S_BEAT2;
            end
            OP_BNK: if (NBANKS > 1) w_bank_next = r_acc[BW-1:0];
            default: ;
          endcase
        end
      end
      S_BEAT2: begin
        w_we         = 1'b1;
        w_wbank      = r_fim_bank;
        w_waddr      = r_fim_addr;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= S_IDLE;
    else if (!halt) r_state <= w_state_next;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_acc      <= '0;
      r_carry    <= 1'b1;
      r_bank     <= '0;
      r_fim_bank <= '0;
      r_fim_addr <= '0;
      r_test_s1  <= 1'b0;
      r_test_s2  <= 1'b0;
    end else if (!halt) begin
      r_acc      <= w_acc_next;
      r_carry    <= w_carry_next;
      r_bank     <= w_bank_next;
      r_fim_bank <= w_fim_bank_next;
      r_fim_addr <= w_fim_addr_next;
      r_test_s1  <= test;
      r_test_s2  <= r_test_s1;
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < NBANKS; gi++) begin : g_bank
      for (gj = 0; gj < NREGS; gj++) begin : g_reg
        always_ff @(posedge clock) begin
          if (!reset_n) r_regs[gi][gj] <= '0;
          else if (!halt && w_we && w_wbank == BW'(gi) && w_waddr == RW'(gj))
            r_regs[gi][gj] <= w_wdata;
        end
      end
    end
  endgenerate

  assign acc         = r_acc;
  assign carry       = r_carry;
  assign bank        = r_bank;
  assign busy        = (r_state == S_BEAT2);
  assign regval      = w_rd;
  assign reg_is_zero = (w_rd == '0);
  assign take_branch = cond[3] ^ ((cond[0] & r_test_s2) | (cond[1] & r_carry) |
                                  (cond[2] & (r_acc == '0)));
endmodule
